// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit: opcodes, T-state encodings and
// the control word that the microcode sequencer drives into the datapath.
package cpu_ctrl_pkg;

  localparam int T_STATES = 6;

  typedef logic [T_STATES-1:0] tstate_t;

  localparam tstate_t T1 = 6'b000001;
  localparam tstate_t T2 = 6'b000010;
  localparam tstate_t T3 = 6'b000100;
  localparam tstate_t T4 = 6'b001000;
  localparam tstate_t T5 = 6'b010000;
  localparam tstate_t T6 = 6'b100000;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LDA    = 8'h01;
  localparam logic [7:0] OP_ADD    = 8'h02;
  localparam logic [7:0] OP_SUB    = 8'h03;
  localparam logic [7:0] OP_STA    = 8'h04;
  localparam logic [7:0] OP_OUT    = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_MVI_B  = 8'h07;
  localparam logic [7:0] OP_MOV_BA = 8'h08;
  localparam logic [7:0] OP_HLT    = 8'h0A;

  typedef struct packed {
    logic count_pc;
    logic clear_pc;
    logic enable_pc;
    logic load_pc;
    logic load_mar;
    logic ce_ram;
    logic we_ram;
    logic load_mdr_reg;
    logic enable_mdr_reg;
    logic load_inst_reg;
    logic enable_inst_reg;
    logic clear_inst_reg;
    logic load_accum;
    logic enable_accum;
    logic enable_alu;
    logic sub_mode;
    logic load_b_reg;
    logic enable_b_reg;
    logic load_c_reg;
    logic enable_c_reg;
    logic load_temp_reg;
    logic load_output_reg;
    logic extended_fetch;
    logic enable_ring_counter;
    logic hlt_clk;
  } ctrl_word_t;

endpackage

// File: rtl/t_state_counter.sv
// One-hot T-state ring with a sticky halt flag; clear returns it to T1 and
// only clear can release a halt.
//
//   state      | meaning
//   T1..T6     | ring_q one-hot, halted_q = 0, stepping the instruction
//   HALT       | ring_q = 0, halted_q = 1, frozen until clear
module t_state_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int T_WIDTH = 6
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               advance,
  input  logic               restart,
  input  logic               halt,
  output logic [T_WIDTH-1:0] t_state,
  output logic               halted
);

  logic [T_WIDTH-1:0] ring_q, ring_d;
  logic               halted_q, halted_d;

  always_comb begin
    ring_d   = ring_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (halt) begin
        ring_d   = '0;
        halted_d = 1'b1;
      end else if (restart) begin
        ring_d = T_WIDTH'(1);
      end else if (advance) begin
        ring_d = {ring_q[T_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      ring_q   <= T_WIDTH'(1);
      halted_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      halted_q <= halted_d;
    end
  end

  assign t_state = ring_q;
  assign halted  = halted_q;

endmodule

// File: rtl/microcode_sequencer.sv
// Opcode decoder for the 8-bit CPU: turns the registered T-state, halt flag
// and instruction register into the per-cycle datapath control word.
module microcode_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int T_WIDTH = 6
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [7:0]         instr,
  output logic [T_WIDTH-1:0] t_state,
  output logic               count_pc,
  output logic               clear_pc,
  output logic               enable_pc,
  output logic               load_pc,
  output logic               load_mar,
  output logic               ce_ram,
  output logic               we_ram,
  output logic               load_mdr_reg,
  output logic               enable_mdr_reg,
  output logic               load_inst_reg,
  output logic               enable_inst_reg,
  output logic               clear_inst_reg,
  output logic               load_accum,
  output logic               enable_accum,
  output logic               enable_alu,
  output logic               sub_mode,
  output logic               load_b_reg,
  output logic               enable_b_reg,
  output logic               load_c_reg,
  output logic               enable_c_reg,
  output logic               load_temp_reg,
  output logic               load_output_reg,
  output logic               extended_fetch,
  output logic               enable_ring_counter,
  output logic               hlt_clk
);

  logic [T_WIDTH-1:0] ring;
  logic               halted;
  logic               advance, restart, halt;
  logic               in_halt;
  tstate_t            ts;
  ctrl_word_t         cw;

  t_state_counter #(.T_WIDTH(T_WIDTH)) u_ring (
    .clk     (clk),
    .clear   (clear),
    .advance (advance),
    .restart (restart),
    .halt    (halt),
    .t_state (ring),
    .halted  (halted)
  );

  assign ts = ring[T_STATES-1:0];

  // HLT shows as halted already in its T3 cycle; the flag registers at that edge.
  assign in_halt = halted || (ts == T3 && instr == OP_HLT);

  always_comb begin
    cw      = '0;
    advance = 1'b0;
    restart = 1'b0;
    halt    = 1'b0;
    if (in_halt) begin
      cw.hlt_clk = 1'b1;
      halt       = !halted;
    end else begin
      cw.enable_ring_counter = 1'b1;
      case (ts)
        T1: begin
          cw.enable_pc = 1'b1;
          cw.load_mar  = 1'b1;
          advance      = 1'b1;
        end
        T2: begin
          cw.ce_ram        = 1'b1;
          cw.load_inst_reg = 1'b1;
          cw.count_pc      = 1'b1;
          advance          = 1'b1;
        end
        T3: begin
          restart = 1'b1;
          case (instr)
            OP_ADD: begin
              cw.enable_alu = 1'b1;
              cw.load_accum = 1'b1;
            end
            OP_SUB: begin
              cw.enable_alu = 1'b1;
              cw.load_accum = 1'b1;
              cw.sub_mode   = 1'b1;
            end
            OP_OUT: begin
              cw.enable_accum    = 1'b1;
              cw.load_output_reg = 1'b1;
            end
            OP_MOV_BA: begin
              cw.enable_accum = 1'b1;
              cw.load_b_reg   = 1'b1;
            end
            OP_LDA, OP_STA, OP_JMP, OP_MVI_B: begin
              cw.extended_fetch = 1'b1;
              cw.enable_pc      = 1'b1;
              cw.load_mar       = 1'b1;
              restart           = 1'b0;
              advance           = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          cw.extended_fetch = 1'b1;
          cw.ce_ram         = 1'b1;
          cw.load_mdr_reg   = 1'b1;
          cw.count_pc       = 1'b1;
          advance           = 1'b1;
        end
        T5: begin
          cw.extended_fetch = 1'b1;
          cw.enable_mdr_reg = 1'b1;
          restart           = 1'b1;
          case (instr)
            OP_LDA, OP_STA: begin
              cw.load_mar = 1'b1;
              restart     = 1'b0;
              advance     = 1'b1;
            end
            OP_JMP:   cw.load_pc    = 1'b1;
            OP_MVI_B: cw.load_b_reg = 1'b1;
            default: ;
          endcase
        end
        T6: begin
          restart = 1'b1;
          case (instr)
            OP_LDA: begin
              cw.ce_ram     = 1'b1;
              cw.load_accum = 1'b1;
            end
            OP_STA: begin
              cw.enable_accum = 1'b1;
              cw.we_ram       = 1'b1;
            end
            default: ;
          endcase
        end
        default: restart = 1'b1;
      endcase
    end
    if (clear) begin
      cw                = '0;
      cw.clear_pc       = 1'b1;
      cw.clear_inst_reg = 1'b1;
    end
  end

  assign t_state = (clear || in_halt) ? '0 : ring;

  assign count_pc            = cw.count_pc;
  assign clear_pc            = cw.clear_pc;
  assign enable_pc           = cw.enable_pc;
  assign load_pc             = cw.load_pc;
  assign load_mar            = cw.load_mar;
  assign ce_ram              = cw.ce_ram;
  assign we_ram              = cw.we_ram;
  assign load_mdr_reg        = cw.load_mdr_reg;
  assign enable_mdr_reg      = cw.enable_mdr_reg;
  assign load_inst_reg       = cw.load_inst_reg;
  assign enable_inst_reg     = cw.enable_inst_reg;
  assign clear_inst_reg      = cw.clear_inst_reg;
  assign load_accum          = cw.load_accum;
  assign enable_accum        = cw.enable_accum;
  assign enable_alu          = cw.enable_alu;
  assign sub_mode            = cw.sub_mode;
  assign load_b_reg          = cw.load_b_reg;
  assign enable_b_reg        = cw.enable_b_reg;
  assign load_c_reg          = cw.load_c_reg;
  assign enable_c_reg        = cw.enable_c_reg;
  assign load_temp_reg       = cw.load_temp_reg;
  assign load_output_reg     = cw.load_output_reg;
  assign extended_fetch      = cw.extended_fetch;
  assign enable_ring_counter = cw.enable_ring_counter;
  assign hlt_clk             = cw.hlt_clk;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for the microcode sequencer: steps each opcode cycle by cycle
// and compares T-state and the full control word against hand-built values.
module tb_microcode_sequencer;

  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          clear;
  logic [7:0]    instr;
  logic [TW-1:0] t_state;
  logic count_pc, clear_pc, enable_pc, load_pc, load_mar, ce_ram, we_ram;
  logic load_mdr_reg, enable_mdr_reg, load_inst_reg, enable_inst_reg, clear_inst_reg;
  logic load_accum, enable_accum, enable_alu, sub_mode;
  logic load_b_reg, enable_b_reg, load_c_reg, enable_c_reg, load_temp_reg, load_output_reg;
  logic extended_fetch, enable_ring_counter, hlt_clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] CPC  = 32'd1 << 0;
  localparam logic [31:0] CLPC = 32'd1 << 1;
  localparam logic [31:0] EPC  = 32'd1 << 2;
  localparam logic [31:0] LPC  = 32'd1 << 3;
  localparam logic [31:0] LMAR = 32'd1 << 4;
  localparam logic [31:0] CE   = 32'd1 << 5;
  localparam logic [31:0] WE   = 32'd1 << 6;
  localparam logic [31:0] LMDR = 32'd1 << 7;
  localparam logic [31:0] EMDR = 32'd1 << 8;
  localparam logic [31:0] LIR  = 32'd1 << 9;
  localparam logic [31:0] CLIR = 32'd1 << 11;
  localparam logic [31:0] LA   = 32'd1 << 12;
  localparam logic [31:0] EA   = 32'd1 << 13;
  localparam logic [31:0] EU   = 32'd1 << 14;
  localparam logic [31:0] SU   = 32'd1 << 15;
  localparam logic [31:0] LB   = 32'd1 << 16;
  localparam logic [31:0] LO   = 32'd1 << 21;
  localparam logic [31:0] XF   = 32'd1 << 22;
  localparam logic [31:0] ERC  = 32'd1 << 23;
  localparam logic [31:0] HLT  = 32'd1 << 24;

  microcode_sequencer #(.T_WIDTH(TW)) dut (
    .clk                 (clk),
    .clear               (clear),
    .instr               (instr),
    .t_state             (t_state),
    .count_pc            (count_pc),
    .clear_pc            (clear_pc),
    .enable_pc           (enable_pc),
    .load_pc             (load_pc),
    .load_mar            (load_mar),
    .ce_ram              (ce_ram),
    .we_ram              (we_ram),
    .load_mdr_reg        (load_mdr_reg),
    .enable_mdr_reg      (enable_mdr_reg),
    .load_inst_reg       (load_inst_reg),
    .enable_inst_reg     (enable_inst_reg),
    .clear_inst_reg      (clear_inst_reg),
    .load_accum          (load_accum),
    .enable_accum        (enable_accum),
    .enable_alu          (enable_alu),
    .sub_mode            (sub_mode),
    .load_b_reg          (load_b_reg),
    .enable_b_reg        (enable_b_reg),
    .load_c_reg          (load_c_reg),
    .enable_c_reg        (enable_c_reg),
    .load_temp_reg       (load_temp_reg),
    .load_output_reg     (load_output_reg),
    .extended_fetch      (extended_fetch),
    .enable_ring_counter (enable_ring_counter),
    .hlt_clk             (hlt_clk)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs_word();
    return {7'd0, hlt_clk, enable_ring_counter, extended_fetch, load_output_reg,
            load_temp_reg, enable_c_reg, load_c_reg, enable_b_reg, load_b_reg,
            sub_mode, enable_alu, enable_accum, load_accum, clear_inst_reg,
            enable_inst_reg, load_inst_reg, enable_mdr_reg, load_mdr_reg, we_ram,
            ce_ram, load_mar, load_pc, enable_pc, clear_pc, count_pc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the current cycle, then move one clock past the next rising edge.
  task automatic cyc(input string tag, input logic [TW-1:0] exp_t, input logic [31:0] exp_w);
    logic [7:0] bus;
    #1;
    bus = {enable_pc, ce_ram, enable_mdr_reg, enable_accum, enable_alu,
           enable_b_reg, enable_c_reg, enable_inst_reg};
    chk({tag, "_t"}, 32'(t_state), 32'(exp_t));
    chk({tag, "_cw"}, obs_word(), exp_w);
    chk({tag, "_bus1h"}, 32'($countones(bus) <= 1), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_T1"}, 6'b000001, ERC | EPC | LMAR);
    cyc({tag, "_T2"}, 6'b000010, ERC | CE | LIR | CPC);
  endtask

  task automatic operand_t3_t4(input string tag);
    cyc({tag, "_T3"}, 6'b000100, ERC | XF | EPC | LMAR);
    cyc({tag, "_T4"}, 6'b001000, ERC | XF | CE | LMDR | CPC);
  endtask

  initial begin
    clear = 1'b1;
    instr = 8'h00;
    cyc("rst", 6'b000000, CLPC | CLIR);
    clear = 1'b0;

    instr = 8'h02; fetch("add"); cyc("add_T3", 6'b000100, ERC | EU | LA);
    instr = 8'h03; fetch("sub"); cyc("sub_T3", 6'b000100, ERC | EU | LA | SU);
    instr = 8'h05; fetch("out"); cyc("out_T3", 6'b000100, ERC | EA | LO);
    instr = 8'h08; fetch("mov"); cyc("mov_T3", 6'b000100, ERC | EA | LB);
    instr = 8'h00; fetch("nop"); cyc("nop_T3", 6'b000100, ERC);
    instr = 8'hFF; fetch("ill"); cyc("ill_T3", 6'b000100, ERC);

    instr = 8'h01; fetch("lda"); operand_t3_t4("lda");
    cyc("lda_T5", 6'b010000, ERC | XF | EMDR | LMAR);
    cyc("lda_T6", 6'b100000, ERC | CE | LA);

    instr = 8'h04; fetch("sta"); operand_t3_t4("sta");
    cyc("sta_T5", 6'b010000, ERC | XF | EMDR | LMAR);
    cyc("sta_T6", 6'b100000, ERC | EA | WE);

    instr = 8'h06; fetch("jmp"); operand_t3_t4("jmp");
    cyc("jmp_T5", 6'b010000, ERC | XF | EMDR | LPC);

    instr = 8'h07; fetch("mvi"); operand_t3_t4("mvi");
    cyc("mvi_T5", 6'b010000, ERC | XF | EMDR | LB);

    instr = 8'h0A; fetch("hlt");
    for (int i = 0; i < 20; i++) cyc("hlt_hold", 6'b000000, HLT);
    clear = 1'b1;
    cyc("hlt_clr", 6'b000000, CLPC | CLIR);
    clear = 1'b0;

    instr = 8'h04; fetch("stac"); operand_t3_t4("stac");
    clear = 1'b1;
    cyc("stac_clr", 6'b000000, CLPC | CLIR);
    clear = 1'b0;
    instr = 8'h00; fetch("post"); cyc("post_T3", 6'b000100, ERC);
    cyc("post_T1", 6'b000001, ERC | EPC | LMAR);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
